// File: rtl/uart_rx_oversample.sv
// UART receiver with 16x oversampling, 3-sample majority vote, parity/framing checks
// and a one-entry valid/ready holding register with sticky overrun.
module uart_rx_oversample #(
  parameter int unsigned SYS_CLK_FREQ = 100000000,
  parameter int unsigned BAUD_RATE    = 115200,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY_MODE  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int unsigned DIV_RAW = SYS_CLK_FREQ / (BAUD_RATE * 16);
  localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int unsigned DW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned IW      = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state, state_nxt;
  logic                 sync1, rx_s;
  logic [DW-1:0]        div_cnt;
  logic [3:0]           s;
  logic [2:0]           smp;
  logic [IW-1:0]        idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 perr, armed;
  logic                 dlv_pend, dlv_ferr;
  logic                 tick, resolve, stop_now, start_det;
  logic                 vote, vote_stop, exp_par, consume;

  assign tick      = (state != IDLE) && (div_cnt == DW'(DIV - 1));
  assign resolve   = tick && (s == 4'd15);
  assign stop_now  = (state == STOP) && tick && (s == 4'd9);
  assign start_det = (state == IDLE) && armed && !rx_s;
  assign vote      = (smp[0] & smp[1]) | (smp[0] & smp[2]) | (smp[1] & smp[2]);
  // stop bit is decided at s=9, so its third sample is the live synchronised line
  assign vote_stop = (smp[0] & smp[1]) | (smp[0] & rx_s) | (smp[1] & rx_s);
  assign exp_par   = (PARITY_MODE == 2) ? (^shreg) : (~^shreg);
  assign consume   = rx_valid && rx_ready;

  // two-flop synchroniser for the asynchronous line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= rx;
      rx_s  <= sync1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (start_det) state_nxt = START;
      START:  if (resolve) state_nxt = vote ? IDLE : DATA;
      DATA:   if (resolve && (idx == IW'(DATA_BITS - 1)))
                state_nxt = (PARITY_MODE != 0) ? PARITY : STOP;
      PARITY: if (resolve) state_nxt = STOP;
      STOP:   if (stop_now) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // oversampling counters, shift register and per-frame error capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt  <= '0;
      s        <= '0;
      smp      <= '0;
      idx      <= '0;
      shreg    <= '0;
      perr     <= 1'b0;
      armed    <= 1'b1;
      dlv_pend <= 1'b0;
      dlv_ferr <= 1'b0;
    end else begin
      dlv_pend <= stop_now;
      if (stop_now) dlv_ferr <= ~vote_stop;
      if (state == IDLE) begin
        div_cnt <= '0;
        s       <= '0;
        if (rx_s) armed <= 1'b1;
        if (start_det) begin
          idx   <= '0;
          shreg <= '0;
          perr  <= 1'b0;
        end
      end else begin
        div_cnt <= tick ? '0 : div_cnt + DW'(1);
        if (tick) begin
          s <= s + 4'd1;
          case (s)
            4'd7:    smp[0] <= rx_s;
            4'd8:    smp[1] <= rx_s;
            4'd9:    smp[2] <= rx_s;
            default: ;
          endcase
        end
        if ((state == DATA) && resolve) begin
          shreg <= {vote, shreg[DATA_BITS-1:1]};
          idx   <= idx + IW'(1);
        end
        if ((state == PARITY) && resolve) perr <= vote ^ exp_par;
        // a low stop bit disarms start detection until the line returns high
        if (stop_now && !vote_stop) armed <= 1'b0;
      end
    end
  end

  // one-entry holding register with valid/ready handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else if (dlv_pend) begin
      if (!rx_valid || rx_ready) begin
        rx_data    <= shreg;
        parity_err <= (PARITY_MODE != 0) && perr;
        frame_err  <= dlv_ferr;
        rx_valid   <= 1'b1;
        if (consume) overrun <= 1'b0;
      end else begin
        overrun <= 1'b1;
      end
    end else if (consume) begin
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Self-checking bench for uart_rx_oversample: directed scenarios plus randomized
// frames checked against a frame-level reference model.
module tb_uart_rx_oversample;

  localparam int unsigned BIT = 32;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } rec_t;

  logic       clk, rst, rx, rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, parity_err, frame_err, overrun;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  rec_t got_q[$];
  int   got_cyc[$];
  rec_t exp_q[$];

  uart_rx_oversample #(
    .SYS_CLK_FREQ(3200),
    .BAUD_RATE   (100),
    .DATA_BITS   (8),
    .PARITY_MODE (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // capture every accepted byte, sampled mid-cycle
  always @(negedge clk) begin
    if (!rst && rx_valid && rx_ready) begin
      got_q.push_back({rx_data, parity_err, frame_err});
      got_cyc.push_back(cyc);
    end
  end

  function automatic logic odd_par(input logic [7:0] d);
    return ~^d;
  endfunction

  // reference model of what the receiver must report for a clean frame
  function automatic rec_t model(input logic [7:0] d, input logic par, input logic stp);
    rec_t r;
    r.d  = d;
    r.pe = (par != odd_par(d));
    r.fe = !stp;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) step();
  endtask

  // drive one frame; glitch inverts the line for 1 clk mid-bit (15 = none)
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp, input int glitch);
    logic [10:0] f;
    f = {stp, par, d, 1'b0};
    start_cyc = cyc;
    for (int i = 0; i < 11; i++) begin
      for (int c = 0; c < int'(BIT); c++) begin
        rx = (i == glitch && c == 16) ? ~f[i] : f[i];
        step();
      end
    end
  endtask

  task automatic test_reset();
    rx = 1'b1;
    rx_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({rx_data, rx_valid, parity_err, frame_err, overrun} !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs: got data=%h v=%b pe=%b fe=%b ov=%b, want all 0",
               rx_data, rx_valid, parity_err, frame_err, overrun);
    end
    step();
    rst = 1'b0;
    idle(20);
    checks++;
    if (rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_valid: got %b want 0", rx_valid);
    end
  endtask

  task automatic test_basic();
    int lat;
    got_q.delete(); got_cyc.delete();
    send_frame(8'h55, 1'b1, 1'b1, 15);
    idle(40);
    checks++;
    if (got_q.size() != 1) begin
      errors++;
      $display("FAIL basic_count: got %0d bytes want 1", got_q.size());
    end else begin
      checks++;
      if (got_q[0] !== {8'h55, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL basic_byte: got d=%h pe=%b fe=%b want d=55 pe=0 fe=0", got_q[0].d, got_q[0].pe, got_q[0].fe);
      end
      lat = got_cyc[0] - start_cyc;
      checks++;
      if (lat < 334 || lat > 354) begin
        errors++;
        $display("FAIL basic_latency: got %0d clk want 334..354", lat);
      end
    end
    checks++;
    if (rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_pulse: rx_valid got %b want 0 after consume", rx_valid);
    end
  endtask

  task automatic test_parity_error();
    rec_t e;
    got_q.delete(); got_cyc.delete();
    send_frame(8'hA3, ~odd_par(8'hA3), 1'b1, 15);
    idle(40);
    e = model(8'hA3, ~odd_par(8'hA3), 1'b1);
    checks++;
    if (got_q.size() != 1 || got_q[0] !== e || e.pe !== 1'b1) begin
      errors++;
      $display("FAIL parity_err: got n=%0d first=%h want one %h with pe=1", got_q.size(),
               (got_q.size() > 0) ? got_q[0] : rec_t'(0), e);
    end
  endtask

  task automatic test_frame_error();
    got_q.delete(); got_cyc.delete();
    send_frame(8'h0F, odd_par(8'h0F), 1'b0, 15);
    idle(BIT);
    send_frame(8'h41, odd_par(8'h41), 1'b1, 15);
    idle(40);
    checks++;
    if (got_q.size() != 2) begin
      errors++;
      $display("FAIL frame_count: got %0d bytes want 2", got_q.size());
    end else begin
      checks++;
      if (got_q[0] !== {8'h0F, 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL frame_err_byte: got %h want %h", got_q[0], {8'h0F, 1'b0, 1'b1});
      end
      checks++;
      if (got_q[1] !== {8'h41, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL frame_recover: got %h want %h", got_q[1], {8'h41, 1'b0, 1'b0});
      end
    end
  endtask

  task automatic test_back_to_back();
    got_q.delete(); got_cyc.delete();
    send_frame(8'h41, odd_par(8'h41), 1'b1, 15);
    send_frame(8'h96, odd_par(8'h96), 1'b1, 15);
    idle(40);
    checks++;
    if (got_q.size() != 2 || got_q[0] !== model(8'h41, odd_par(8'h41), 1'b1)
        || got_q[1] !== model(8'h96, odd_par(8'h96), 1'b1)) begin
      errors++;
      $display("FAIL back_to_back: got n=%0d want 41,96 clean", got_q.size());
    end
  endtask

  task automatic test_false_start();
    got_q.delete(); got_cyc.delete();
    rx = 1'b0;
    repeat (6) step();
    idle(40);
    checks++;
    if (got_q.size() != 0 || rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL false_start: got %0d bytes valid=%b want 0 bytes", got_q.size(), rx_valid);
    end
    send_frame(8'h5A, odd_par(8'h5A), 1'b1, 15);
    idle(40);
    checks++;
    if (got_q.size() != 1 || got_q[0] !== model(8'h5A, odd_par(8'h5A), 1'b1)) begin
      errors++;
      $display("FAIL false_start_recover: got n=%0d want one clean 5A", got_q.size());
    end
  endtask

  task automatic test_overrun();
    got_q.delete(); got_cyc.delete();
    rx_ready = 1'b0;
    send_frame(8'h11, odd_par(8'h11), 1'b1, 15);
    send_frame(8'h22, odd_par(8'h22), 1'b1, 15);
    idle(40);
    @(negedge clk);
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h11 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_hold: got v=%b d=%h ov=%b want v=1 d=11 ov=1", rx_valid, rx_data, overrun);
    end
    step();
    rx_ready = 1'b1;
    step();
    rx_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (rx_valid !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_consume: got v=%b ov=%b want 0 0", rx_valid, overrun);
    end
    checks++;
    if (got_q.size() != 1 || got_q[0] !== {8'h11, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL overrun_byte: got n=%0d want one clean 11", got_q.size());
    end
    step();
    rx_ready = 1'b1;
  endtask

  task automatic test_reset_mid_frame();
    logic [10:0] f;
    got_q.delete(); got_cyc.delete();
    f = {1'b1, odd_par(8'h7E), 8'h7E, 1'b0};
    for (int i = 0; i < 4; i++) begin
      rx = f[i];
      repeat (BIT) step();
    end
    rx = f[4];
    repeat (16) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_valid: got %b want 0", rx_valid);
    end
    idle(2 * BIT);
    send_frame(8'h3C, odd_par(8'h3C), 1'b1, 15);
    idle(40);
    checks++;
    if (got_q.size() != 1 || got_q[0] !== {8'h3C, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid_frame: got n=%0d want one clean 3C", got_q.size());
    end
  endtask

  task automatic test_line_low();
    got_q.delete(); got_cyc.delete();
    rx = 1'b0;
    repeat (20 * BIT) step();
    idle(2 * BIT);
    checks++;
    if (got_q.size() != 1 || got_q[0] !== model(8'h00, 1'b0, 1'b0)) begin
      errors++;
      $display("FAIL line_low: got n=%0d want exactly one 00 with pe=1 fe=1", got_q.size());
    end
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic       par, stp;
    int         g;
    got_q.delete(); got_cyc.delete(); exp_q.delete();
    for (int n = 0; n < 16; n++) begin
      d   = 8'($urandom);
      par = ($urandom_range(0, 3) == 0) ? ~odd_par(d) : odd_par(d);
      stp = ($urandom_range(0, 4) != 0);
      g   = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 8)) : 15;
      exp_q.push_back(model(d, par, stp));
      send_frame(d, par, stp, g);
      idle(stp ? int'($urandom_range(0, 20)) : int'($urandom_range(4, 20)));
    end
    idle(40);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL random_count: got %0d bytes want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL random_byte[%0d]: got d=%h pe=%b fe=%b want d=%h pe=%b fe=%b", i,
                 got_q[i].d, got_q[i].pe, got_q[i].fe, exp_q[i].d, exp_q[i].pe, exp_q[i].fe);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity_error();
    test_frame_error();
    test_back_to_back();
    test_false_start();
    test_overrun();
    test_reset_mid_frame();
    test_line_low();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
